// File: rtl/sfu_pkg.sv
// Shared types and default sizes for the SFU feeder slice.
package sfu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int NKIJ    = 9;

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter: counts 0..MAX on inc, flags the MAX->0 step, clr has priority.
module wrap_counter #(
  parameter int MAX   = 8,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign wrap  = inc && (cnt_q == WIDTH'(MAX));
  assign value = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sfu_feeder.sv
// Streams OFIFO psum vectors into the SFU with the acc pattern and writes finished results to SRAM.
// Define SFU_FEEDER_PERF_EN to add the stall_cnt performance counter output.
module sfu_feeder #(
  parameter int PSUM_BW = sfu_pkg::PSUM_BW,
  parameter int COL     = sfu_pkg::COL,
  parameter int NKIJ    = sfu_pkg::NKIJ,
  parameter int NOUT    = 16,
  parameter int ADDR_BW = (NOUT > 1) ? $clog2(NOUT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   ofifo_valid,
  input  logic [PSUM_BW*COL-1:0] ofifo_out,
  output logic                   ofifo_rd,
  output logic                   acc,
  output logic [PSUM_BW*COL-1:0] psum_out,
  output logic                   sfu_reset,
  input  logic [PSUM_BW*COL-1:0] sfp_in,
  output logic                   wr_en,
  output logic [ADDR_BW-1:0]     wr_addr,
  output logic [PSUM_BW*COL-1:0] wr_data,
  output logic                   busy,
  output logic                   done
`ifdef SFU_FEEDER_PERF_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  import sfu_pkg::*;

  localparam int W  = PSUM_BW * COL;
  localparam int KW = $clog2(NKIJ);

  state_e               state_q, state_d;
  logic                 start_ok, pop, kij_wrap, out_wrap;
  logic [KW-1:0]        kij_cnt;
  logic [ADDR_BW-1:0]   out_cnt;
  logic                 acc_q, acc_d;
  logic [W-1:0]         psum_q, psum_d;
  logic                 tag0_vld_q, tag0_vld_d, tag1_vld_q;
  logic [ADDR_BW-1:0]   tag0_addr_q, tag0_addr_d, tag1_addr_q;

  // Popping is suppressed while reset is held so no vector is lost to a clearing edge.
  assign start_ok = (state_q == IDLE) && start;
  assign pop      = reset && (state_q == RUN) && ofifo_valid;

  wrap_counter #(.MAX(NKIJ - 1), .WIDTH(KW)) u_kij_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pop),
    .clr   (start_ok),
    .value (kij_cnt),
    .wrap  (kij_wrap)
  );

  wrap_counter #(.MAX(NOUT - 1), .WIDTH(ADDR_BW)) u_out_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (kij_wrap),
    .clr   (start_ok),
    .value (out_cnt),
    .wrap  (out_wrap)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = 1'b1;
    psum_d      = '0;
    tag0_vld_d  = pop && kij_wrap;
    tag0_addr_d = out_cnt;
    if (pop) begin
      acc_d  = (kij_cnt != KW'(NKIJ - 1));
      psum_d = ofifo_out;
    end
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (out_wrap) state_d = DRAIN;
      DRAIN:   if (tag1_vld_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Idle drive (acc=1, psum=0) makes the SFU add zero, leaving its accumulator untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= 1'b1;
      psum_q      <= '0;
      tag0_vld_q  <= 1'b0;
      tag0_addr_q <= '0;
      tag1_vld_q  <= 1'b0;
      tag1_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      psum_q      <= psum_d;
      tag0_vld_q  <= tag0_vld_d;
      tag0_addr_q <= tag0_addr_d;
      tag1_vld_q  <= tag0_vld_q;
      tag1_addr_q <= tag0_addr_q;
    end
  end

  assign ofifo_rd  = pop;
  assign acc       = acc_q;
  assign psum_out  = psum_q;
  assign sfu_reset = ~reset;
  assign wr_en     = tag1_vld_q;
  assign wr_addr   = tag1_addr_q;
  assign wr_data   = sfp_in;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

`ifdef SFU_FEEDER_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_ok) begin
      stall_d = '0;
    end else if ((state_q == RUN) && !ofifo_valid && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sfu_feeder.sv
// Bench for sfu_feeder: OFIFO stimulus, behavioural SFU, and a write scoreboard.
// Honours SFU_FEEDER_PERF_EN to exercise the stall counter.
`timescale 1ns/1ps
module tb_sfu_feeder;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int NKIJ    = 9;
  localparam int NOUT    = 2;
  localparam int ADDR_BW = 1;
  localparam int W       = PSUM_BW * COL;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               ofifo_valid = 1'b0;
  logic [W-1:0]       ofifo_out = '0;
  logic [W-1:0]       sfp_in;
  logic               ofifo_rd, acc, sfu_reset, wr_en, busy, done;
  logic [W-1:0]       psum_out, wr_data;
  logic [ADDR_BW-1:0] wr_addr;
`ifdef SFU_FEEDER_PERF_EN
  logic [31:0]        stall_cnt;
  logic [31:0]        stallAtDone = '0;
`endif

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int doneCnt = 0;
  int doneCyc = 0;
  int wrCnt   = 0;

  logic [W-1:0] sbData[$];
  int           sbAddr[$];
  int           sbCyc[$];

  logic signed [PSUM_BW-1:0] sfuSum[COL];

  sfu_feeder #(
    .PSUM_BW (PSUM_BW),
    .COL     (COL),
    .NKIJ    (NKIJ),
    .NOUT    (NOUT),
    .ADDR_BW (ADDR_BW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .ofifo_out   (ofifo_out),
    .ofifo_rd    (ofifo_rd),
    .acc         (acc),
    .psum_out    (psum_out),
    .sfu_reset   (sfu_reset),
    .sfp_in      (sfp_in),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done)
`ifdef SFU_FEEDER_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural SFU: accumulate while acc=1, emit ReLU(sum) registered on the acc=0 edge.
  always @(posedge clk) begin
    logic signed [PSUM_BW-1:0] s;
    for (int l = 0; l < COL; l++) begin
      s = sfuSum[l] + psum_out[l*PSUM_BW +: PSUM_BW];
      if (sfu_reset) begin
        sfuSum[l] <= '0;
        sfp_in[l*PSUM_BW +: PSUM_BW] <= '0;
      end else if (acc) begin
        sfuSum[l] <= s;
      end else begin
        sfuSum[l] <= '0;
        sfp_in[l*PSUM_BW +: PSUM_BW] <= (s < 0) ? '0 : s;
      end
    end
  end

  // Write monitor: every SRAM write must match the oldest scoreboard entry.
  always @(negedge clk) begin
    logic [W-1:0] ed;
    int ea;
    int ec;
    if (done) begin
      doneCnt++;
      doneCyc = cyc;
`ifdef SFU_FEEDER_PERF_EN
      stallAtDone = stall_cnt;
`endif
    end
    if (wr_en) begin
      wrCnt++;
      nChecks++;
      if (sbData.size() == 0) begin
        nFails++;
        $display("[TB] FAIL unexpected_write: got addr %0d, required no write", wr_addr);
      end else begin
        ed = sbData.pop_front();
        ea = sbAddr.pop_front();
        ec = sbCyc.pop_front();
        if (wr_data !== ed) begin
          nFails++;
          $display("[TB] FAIL wr_data: got %h required %h", wr_data, ed);
        end
        nChecks++;
        if (wr_addr !== ADDR_BW'(ea)) begin
          nFails++;
          $display("[TB] FAIL wr_addr: got %0d required %0d", wr_addr, ea);
        end
        nChecks++;
        if (cyc != ec) begin
          nFails++;
          $display("[TB] FAIL wr_latency: write at cycle %0d required %0d", cyc, ec);
        end
      end
    end
  end

  function automatic logic [PSUM_BW-1:0] laneVal(input int mode, input int l);
    if (mode == 1) return 16'd2;
    if (mode == 2 && l == 3) return 16'hFFFF;
    return 16'd1;
  endfunction

  function automatic logic [W-1:0] expResult(input int mode);
    logic [W-1:0] r;
    int total;
    r = '0;
    for (int l = 0; l < COL; l++) begin
      total = NKIJ * int'($signed(laneVal(mode, l)));
      r[l*PSUM_BW +: PSUM_BW] = (total < 0) ? 16'd0 : 16'(total);
    end
    return r;
  endfunction

  // One tile: gapMode 0 always valid, 1 alternate cycles low, 2 five injected stalls.
  task automatic drive_tile(input int mode, input int gapMode, input bit pulse,
                            input int abortPops, input int expDoneCyc);
    int idx, k, o, i, expStall, doneBefore, wrBefore, startCyc;
    bit v, expRd, expAcc;
    logic [W-1:0] vec, expPsum;
    idx = 0; k = 0; o = 0; i = 0; expStall = 0; startCyc = 0;
    doneBefore = doneCnt;
    wrBefore   = wrCnt;
    for (int l = 0; l < COL; l++) vec[l*PSUM_BW +: PSUM_BW] = laneVal(mode, l);
    while (idx < NKIJ * NOUT && i < 200) begin
      @(negedge clk);
      if (i == 0) startCyc = cyc;
      start = (i == 0) || (pulse && i == 6);
      case (gapMode)
        1:       v = (i % 2 == 1);
        2:       v = !(i == 3 || i == 4 || i == 10 || i == 20 || i == 21);
        default: v = 1'b1;
      endcase
      ofifo_valid = v;
      ofifo_out   = vec;
      expRd = (i >= 1) && v;
      if (i >= 1 && !v) expStall++;
      #1;
      nChecks++;
      if (ofifo_rd !== expRd) begin
        nFails++;
        $display("[TB] FAIL ofifo_rd: cycle %0d got %b required %b", i, ofifo_rd, expRd);
      end
      @(posedge clk);
      #1;
      expAcc  = expRd ? (k != NKIJ - 1) : 1'b1;
      expPsum = expRd ? vec : '0;
      nChecks++;
      if (acc !== expAcc) begin
        nFails++;
        $display("[TB] FAIL acc: cycle %0d got %b required %b", i, acc, expAcc);
      end
      nChecks++;
      if (psum_out !== expPsum) begin
        nFails++;
        $display("[TB] FAIL psum_out: cycle %0d got %h required %h", i, psum_out, expPsum);
      end
`ifdef SFU_FEEDER_PERF_EN
      if (i == 0) begin
        nChecks++;
        if (stall_cnt !== 32'd0) begin
          nFails++;
          $display("[TB] FAIL stall_clear: got %0d required 0", stall_cnt);
        end
      end
`endif
      if (expRd) begin
        if (k == NKIJ - 1) begin
          sbData.push_back(expResult(mode));
          sbAddr.push_back(o);
          sbCyc.push_back(cyc + 1);
          k = 0;
          o++;
        end else begin
          k++;
        end
        idx++;
      end
      i++;
      if (abortPops > 0 && idx >= abortPops) break;
    end
    start = 1'b0;
    if (abortPops > 0) return;
    ofifo_valid = 1'b0;
    for (int j = 0; j < 12 && doneCnt == doneBefore; j++) begin
      @(negedge clk);
      start = pulse && (j == 0);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    nChecks++;
    if (doneCnt - doneBefore != 1) begin
      nFails++;
      $display("[TB] FAIL done_count: got %0d required 1", doneCnt - doneBefore);
    end
    nChecks++;
    if (wrCnt - wrBefore != NOUT) begin
      nFails++;
      $display("[TB] FAIL write_count: got %0d required %0d", wrCnt - wrBefore, NOUT);
    end
    nChecks++;
    if (sbData.size() != 0) begin
      nFails++;
      $display("[TB] FAIL pending_writes: got %0d required 0", sbData.size());
      sbData.delete(); sbAddr.delete(); sbCyc.delete();
    end
    nChecks++;
    if (busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL busy_after_tile: got %b required 0", busy);
    end
    if (expDoneCyc > 0) begin
      nChecks++;
      if (doneCyc - startCyc != expDoneCyc) begin
        nFails++;
        $display("[TB] FAIL done_cycle: got %0d required %0d", doneCyc - startCyc, expDoneCyc);
      end
    end
`ifdef SFU_FEEDER_PERF_EN
    nChecks++;
    if (stallAtDone !== 32'(expStall)) begin
      nFails++;
      $display("[TB] FAIL stall_cnt: got %0d required %0d", stallAtDone, expStall);
    end
`endif
  endtask

  task automatic check_reset_values(input string tag);
    nChecks++;
    if (ofifo_rd !== 1'b0) begin nFails++; $display("[TB] FAIL %s ofifo_rd: got %b required 0", tag, ofifo_rd); end
    nChecks++;
    if (acc !== 1'b1) begin nFails++; $display("[TB] FAIL %s acc: got %b required 1", tag, acc); end
    nChecks++;
    if (psum_out !== '0) begin nFails++; $display("[TB] FAIL %s psum_out: got %h required 0", tag, psum_out); end
    nChecks++;
    if (wr_en !== 1'b0) begin nFails++; $display("[TB] FAIL %s wr_en: got %b required 0", tag, wr_en); end
    nChecks++;
    if (wr_addr !== '0) begin nFails++; $display("[TB] FAIL %s wr_addr: got %0d required 0", tag, wr_addr); end
    nChecks++;
    if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL %s busy: got %b required 0", tag, busy); end
    nChecks++;
    if (done !== 1'b0) begin nFails++; $display("[TB] FAIL %s done: got %b required 0", tag, done); end
    nChecks++;
    if (sfu_reset !== 1'b1) begin nFails++; $display("[TB] FAIL %s sfu_reset: got %b required 1", tag, sfu_reset); end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    reset = 1'b0;
    ofifo_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    ofifo_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    $display("[TB] test_basic");
    drive_tile(0, 0, 1'b0, 0, 21);
  endtask

  task automatic test_gaps();
    $display("[TB] test_gaps");
    drive_tile(0, 1, 1'b0, 0, 0);
  endtask

  task automatic test_relu();
    $display("[TB] test_relu");
    drive_tile(2, 0, 1'b0, 0, 21);
  endtask

  task automatic test_start_ignored();
    $display("[TB] test_start_ignored");
    drive_tile(0, 0, 1'b1, 0, 21);
  endtask

  task automatic test_reset_mid();
    $display("[TB] test_reset_mid");
    drive_tile(0, 0, 1'b0, 5, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_mid");
    ofifo_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    drive_tile(1, 0, 1'b0, 0, 21);
  endtask

  task automatic test_perf();
`ifdef SFU_FEEDER_PERF_EN
    $display("[TB] test_perf");
    drive_tile(0, 2, 1'b0, 0, 0);
    drive_tile(0, 0, 1'b0, 0, 21);
`else
    $display("[TB] test_perf skipped, counter not built");
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_relu();
    test_start_ignored();
    test_reset_mid();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
